cfu_host_driver: RTL and testbench
==================================

CFU_HOST_DRIVER -- requirements
Module: cfu_host_driver

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4, idle cycles between SET_VALID response and first IS_BUSY poll.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have job ports: start in 1 job trigger; job_k/job_m/job_n in 8 each dims; job_offset in 32; a_count, b_count, c_rows in 12 each.
REQ-004 SHALL have source stream: src_valid in 1; src_ready out 1; src_data in 32 (a_count A words, then b_count B words).
REQ-005 SHALL have CFU command port: cmd_valid out 1; cmd_ready in 1; cmd_payload_function_id out 10; cmd_payload_inputs_0 out 32; cmd_payload_inputs_1 out 32.
REQ-006 SHALL have CFU response port: rsp_valid in 1; rsp_ready out 1; rsp_payload_outputs_0 in 32.
REQ-007 SHALL have result stream: c_valid out 1; c_ready in 1; c_data out 32.
REQ-008 SHALL have status: busy out 1; done out 1 (one-cycle pulse); poll_cnt out 16 (IS_BUSY polls this job, saturating).

Function
REQ-009 function_id SHALL be {funct7, 3'b000}; funct7: RESET 0, SET_KMN 1, STORE_A 2, STORE_B 3, IS_BUSY 4, OUTPUT_C 5, SET_OFFSET 6, SET_VALID 7.
REQ-010 States SHALL be IDLE, RST, KMN, OFS, STA, STB, VALID, SETTLE, POLL, RDC, DONE, in that order; each command state issues one command per transaction.
REQ-011 Transaction: drive cmd_valid with stable payload until cmd_valid&&cmd_ready; next cycle onward assert rsp_ready until rsp_valid&&rsp_ready; at most one command outstanding.
REQ-012 cmd_valid SHALL NOT be asserted while a response is pending; rsp_ready SHALL be 0 outside the response phase.
REQ-013 Unused payload inputs SHALL be driven 0.
REQ-014 IDLE: busy=0; start=1 latches all job_* inputs and counts, clears poll_cnt, enters RST; start while busy=1 SHALL be ignored.
REQ-015 KMN payload: inputs_0 = {8'd0, job_k, job_m, job_n}; OFS payload: inputs_0 = job_offset.
REQ-016 STA: per word, wait src_valid, pulse src_ready for one cycle in the same cycle cmd handshake completes, send STORE_A with inputs_0=src_data; repeat a_count times.
REQ-017 STB: same as STA but STORE_B with data in inputs_1, inputs_0=0; repeat b_count times.
REQ-018 a_count==0 or b_count==0 SHALL skip the respective state with no src_ready pulse.
REQ-019 VALID: send SET_VALID once; then SETTLE waits exactly SETTLE_CYC cycles with no command.
REQ-020 POLL: send IS_BUSY; response 1 -> increment poll_cnt (saturate 16'hFFFF), re-issue next cycle; response 0 -> RDC (or DONE if c_rows==0).
REQ-021 RDC: for row 0..c_rows-1, lane 0..3, send OUTPUT_C with inputs_0 = {30'd0, lane}; lane 3 completes the row.
REQ-022 Each RDC response SHALL load c_data and set c_valid; c_valid holds until c_ready; rsp_ready in RDC SHALL be asserted only while c_valid==0 or c_ready==1.
REQ-023 DONE: wait c_valid==0, pulse done one cycle, return to IDLE.
REQ-024 Counters SHALL be 12 bits; a_count/b_count/c_rows = 4095 SHALL complete without wrap error.
REQ-025 Source stall (src_valid=0) SHALL hold cmd_valid=0; no timeout.

Reset
REQ-026 On reset: state IDLE; cmd_valid, rsp_ready, src_ready, c_valid, busy, done = 0; poll_cnt=0; payload outputs=0.
REQ-027 Reset mid-transaction SHALL abandon it; the CFU shares the same reset.

Verification
REQ-028 K=4,M=4,N=4, a_count=b_count=4, c_rows=1, responder busy 10 cycles -> command order RESET,SET_KMN(inputs_0=0x00040404),SET_OFFSET,4xSTORE_A,4xSTORE_B,SET_VALID,IS_BUSY...,4xOUTPUT_C lanes 0..3, done pulse.
REQ-029 Responder holds cmd_ready=0 5 cycles on STORE_A -> cmd_valid and payload stable throughout; src_ready pulses once per word.
REQ-030 IS_BUSY returns 1 three times then 0 -> poll_cnt=3, first IS_BUSY exactly SETTLE_CYC cycles after SET_VALID response.
REQ-031 c_ready=0 for 20 cycles during RDC -> single c_data held, rsp_ready=0, no OUTPUT_C issued until drained.
REQ-032 a_count=0, c_rows=0 -> no STORE_A, no OUTPUT_C; done after poll returns 0.
REQ-033 Reset asserted during STB -> next cycle all outputs at reset values; start ignored while busy=1.

Source files
------------

// File: rtl/cfu_host_driver.sv
// Host-side sequencer that walks a CFU through one matmul job:
// configure, stream A/B operands, wait for completion, then read C back lane by lane.
module cfu_host_driver #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  job_k,
  input  logic [7:0]  job_m,
  input  logic [7:0]  job_n,
  input  logic [31:0] job_offset,
  input  logic [11:0] a_count,
  input  logic [11:0] b_count,
  input  logic [11:0] c_rows,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [31:0] src_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        c_valid,
  input  logic        c_ready,
  output logic [31:0] c_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] poll_cnt
);

  localparam int unsigned CW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 10;
  localparam int unsigned SW = 16;
  localparam int unsigned PW = 16;

  typedef enum logic [3:0] {
    IDLE, RST, KMN, OFS, STA, STB, VALID, SETTLE, POLL, RDC, DONE
  } state_e;

  state_e          state_q, state_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [FW-1:0]   fid_q, fid_d;
  logic [DW-1:0]   in0_q, in0_d, in1_q, in1_d;
  logic            rsp_wait_q, rsp_wait_d;
  logic            c_valid_q, c_valid_d;
  logic [DW-1:0]   c_data_q, c_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [7:0]      k_q, m_q, n_q;
  logic [DW-1:0]   off_q;
  logic [CW-1:0]   a_cnt_q, b_cnt_q, rows_q;
  logic            rsp_fire;
  logic            issue;

  // CFU function id for the command each state sends.
  function automatic logic [FW-1:0] fid_of(state_e s);
    logic [6:0] f7;
    f7 = 7'd0;
    case (s)
      KMN:     f7 = 7'd1;
      STA:     f7 = 7'd2;
      STB:     f7 = 7'd3;
      POLL:    f7 = 7'd4;
      RDC:     f7 = 7'd5;
      OFS:     f7 = 7'd6;
      VALID:   f7 = 7'd7;
      default: f7 = 7'd0;
    endcase
    return {f7, 3'b000};
  endfunction

  // Operand phases with a zero count are skipped entirely.
  function automatic state_e next_stream(state_e cur, logic [CW-1:0] a, logic [CW-1:0] b);
    if (cur == OFS && a != '0) return STA;
    if (cur != STB && b != '0) return STB;
    return VALID;
  endfunction

  assign rsp_ready = rsp_wait_q && (state_q != RDC || !c_valid_q || c_ready);
  assign src_ready = (state_q == STA || state_q == STB) && cmd_valid_q && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    fid_d       = fid_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    rsp_wait_d  = rsp_wait_q;
    c_valid_d   = c_valid_q;
    c_data_d    = c_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    poll_d      = poll_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    settle_d    = settle_q;
    issue       = 1'b0;

    if (c_valid_q && c_ready) c_valid_d = 1'b0;

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      rsp_wait_d  = 1'b1;
      fid_d       = '0;
      in0_d       = '0;
      in1_d       = '0;
    end
    if (rsp_fire) rsp_wait_d = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        busy_d  = 1'b1;
        poll_d  = '0;
        idx_d   = '0;
        lane_d  = '0;
        state_d = RST;
        issue   = 1'b1;
      end
      RST: if (rsp_fire) begin
        state_d = KMN;
        issue   = 1'b1;
      end
      KMN: if (rsp_fire) begin
        state_d = OFS;
        issue   = 1'b1;
      end
      OFS: if (rsp_fire) begin
        state_d = next_stream(OFS, a_cnt_q, b_cnt_q);
        issue   = (state_d == VALID);
      end
      STA, STB: begin
        // Data is captured into the payload now; the source is released at the handshake.
        if (!cmd_valid_q && !rsp_wait_q && src_valid) begin
          cmd_valid_d = 1'b1;
          fid_d       = fid_of(state_q);
          in0_d       = (state_q == STA) ? src_data : '0;
          in1_d       = (state_q == STB) ? src_data : '0;
        end
        if (rsp_fire) begin
          if (idx_q + CW'(1) == ((state_q == STA) ? a_cnt_q : b_cnt_q)) begin
            idx_d   = '0;
            state_d = next_stream(state_q, a_cnt_q, b_cnt_q);
            issue   = (state_d == VALID);
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      VALID: if (rsp_fire) begin
        settle_d = '0;
        if (SETTLE_CYC == 0) begin
          state_d = POLL;
          issue   = 1'b1;
        end else begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = POLL;
          issue   = 1'b1;
        end
      end
      POLL: if (rsp_fire) begin
        if (rsp_payload_outputs_0 != '0) begin
          if (poll_q != '1) poll_d = poll_q + PW'(1);
          issue = 1'b1;
        end else if (rows_q != '0) begin
          state_d = RDC;
          idx_d   = '0;
          lane_d  = '0;
        end else begin
          state_d = DONE;
        end
      end
      RDC: begin
        // Next lane is only requested once the previous result word has left.
        if (!cmd_valid_q && !rsp_wait_q && (!c_valid_q || c_ready)) issue = 1'b1;
        if (rsp_fire) begin
          c_valid_d = 1'b1;
          c_data_d  = rsp_payload_outputs_0;
          lane_d    = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            idx_d = idx_q + CW'(1);
            if (idx_q + CW'(1) == rows_q) state_d = DONE;
          end
        end
      end
      DONE: if (!c_valid_q) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      cmd_valid_d = 1'b1;
      fid_d       = fid_of(state_d);
      in0_d       = '0;
      in1_d       = '0;
      case (state_d)
        KMN:     in0_d = {8'd0, k_q, m_q, n_q};
        OFS:     in0_d = off_q;
        RDC:     in0_d = {30'd0, lane_d};
        default: in0_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      fid_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      rsp_wait_q  <= 1'b0;
      c_valid_q   <= 1'b0;
      c_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      poll_q      <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      fid_q       <= fid_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rsp_wait_q  <= rsp_wait_d;
      c_valid_q   <= c_valid_d;
      c_data_q    <= c_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      poll_q      <= poll_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      settle_q    <= settle_d;
    end
  end

  // Job descriptor is captured only when a new job is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      off_q   <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      rows_q  <= '0;
    end else if (state_q == IDLE && start) begin
      k_q     <= job_k;
      m_q     <= job_m;
      n_q     <= job_n;
      off_q   <= job_offset;
      a_cnt_q <= a_count;
      b_cnt_q <= b_count;
      rows_q  <= c_rows;
    end
  end

  assign cmd_valid               = cmd_valid_q;
  assign cmd_payload_function_id = fid_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;
  assign c_valid                 = c_valid_q;
  assign c_data                  = c_data_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign poll_cnt                = poll_q;

endmodule

// File: tb/tb_cfu_host_driver.sv
// Bench for cfu_host_driver: a reactive CFU/source/sink agent plus directed and random jobs
// checked against the command/result sequence each job must produce.
module tb_cfu_host_driver;

  localparam int unsigned SETTLE = 4;
  localparam logic [9:0] F_RST = 10'd0,  F_KMN = 10'd8,  F_STA = 10'd16, F_STB = 10'd24;
  localparam logic [9:0] F_POLL = 10'd32, F_OUTC = 10'd40, F_OFS = 10'd48, F_VALID = 10'd56;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0;
  logic [7:0]  job_k = '0, job_m = '0, job_n = '0;
  logic [31:0] job_offset = '0;
  logic [11:0] a_count = '0, b_count = '0, c_rows = '0;
  logic        src_valid = 1'b0, src_ready;
  logic [31:0] src_data = '0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid = 1'b0, rsp_ready;
  logic [31:0] rsp_payload_outputs_0 = '0;
  logic        c_valid, c_ready = 1'b1;
  logic [31:0] c_data;
  logic        busy, done;
  logic [15:0] poll_cnt;

  cfu_host_driver #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .job_k(job_k), .job_m(job_m), .job_n(job_n), .job_offset(job_offset),
    .a_count(a_count), .b_count(b_count), .c_rows(c_rows),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .busy(busy), .done(done), .poll_cnt(poll_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [73:0] cmd(input logic [9:0] f, input logic [31:0] i0, input logic [31:0] i1);
    return {f, i0, i1};
  endfunction

  // Result word the CFU returns for the i-th OUTPUT_C of a job.
  function automatic logic [31:0] c_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h5A5A_0001;
  endfunction

  // Agent configuration and bookkeeping
  bit          cfg_stall_a = 0, cfg_c_freeze = 0, cfg_rnd = 0;
  logic [31:0] src_q[$];
  bit          src_on = 0, pending = 0, c_frozen_done = 0, stb_seen = 0;
  int          lat = 0, busy_left = 0, outc_n = 0, cmd_wait = 0, cmd_hold = 0, c_hold_left = 0;
  logic [31:0] rsp_data_r = '0;
  logic [9:0]  pend_fid = '0;
  logic [73:0] log_q[$];
  logic [31:0] got_c[$];
  int          src_pulses = 0, done_cnt = 0, cyc = 0, valid_fire_cyc = -1, first_poll_cyc = -1;
  bit          prev_stall = 0, prev_cmd_valid = 0, prev_c_stall = 0;
  logic [73:0] prev_payload = '0;
  logic [31:0] prev_c_data = '0;

  // Agent: drive inputs at negedge, then observe what the next posedge will accept.
  initial begin : agent
    forever begin
      @(negedge clk);
      cyc++;
      if (cmd_valid) begin
        if (cmd_wait == 0)
          cmd_hold = (cfg_stall_a && cmd_payload_function_id == F_STA) ? 5 :
                     (cfg_rnd ? int'($urandom_range(0, 2)) : 0);
        cmd_ready = (cmd_wait >= cmd_hold);
        cmd_wait++;
      end else begin
        cmd_ready = 1'b0;
      end
      if (pending && lat > 0) lat--;
      rsp_valid             = pending && (lat == 0);
      rsp_payload_outputs_0 = rsp_valid ? rsp_data_r : 32'h0;
      if (!src_on && src_q.size() > 0) src_on = cfg_rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      src_valid = src_on;
      src_data  = src_on ? src_q[0] : 32'h0;
      if (c_valid && cfg_c_freeze && !c_frozen_done) begin
        c_hold_left   = 20;
        c_frozen_done = 1;
      end
      if (c_hold_left > 0) begin
        c_ready = 1'b0;
        c_hold_left--;
      end else begin
        c_ready = cfg_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      if (reset) begin
        pending = 0; lat = 0; src_q.delete(); src_on = 0; cmd_wait = 0; c_hold_left = 0;
        prev_stall = 0; prev_cmd_valid = 0; prev_c_stall = 0;
      end else begin
        check("cmd_while_rsp_pending", 74'(cmd_valid && pending), 74'(0));
        check("rsp_ready_outside_rsp", 74'(rsp_ready && !pending), 74'(0));
        check("rsp_ready_c_backpressure", 74'(rsp_ready && c_valid && !c_ready), 74'(0));
        check("src_ready_without_valid", 74'(src_ready && !src_valid), 74'(0));
        if (prev_stall)
          check("cmd_stable_while_stalled",
                {cmd_valid, cmd(cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1)},
                {1'b1, prev_payload});
        if (prev_c_stall) check("c_data_held", 74'({c_valid, c_data}), 74'({1'b1, prev_c_data}));
        if (cmd_valid && !prev_cmd_valid && cmd_payload_function_id == F_OUTC)
          check("outc_only_after_drain", 74'(c_valid), 74'(0));
        if (cmd_valid && !prev_cmd_valid && cmd_payload_function_id == F_POLL && first_poll_cyc < 0)
          first_poll_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
          pending = 0;
          if (pend_fid == F_VALID) valid_fire_cyc = cyc;
        end
        if (cmd_valid && cmd_ready) begin
          log_q.push_back(cmd(cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1));
          pending  = 1;
          pend_fid = cmd_payload_function_id;
          cmd_wait = 0;
          lat      = cfg_rnd ? int'($urandom_range(0, 2)) : 0;
          if (cmd_payload_function_id == F_POLL) begin
            rsp_data_r = (busy_left > 0) ? 32'd1 : 32'd0;
            if (busy_left > 0) busy_left--;
          end else if (cmd_payload_function_id == F_OUTC) begin
            rsp_data_r = c_word(outc_n);
            outc_n++;
          end else begin
            rsp_data_r = $urandom;
          end
          if (cmd_payload_function_id == F_STB) stb_seen = 1;
        end
        if (src_valid && src_ready) begin
          void'(src_q.pop_front());
          src_on = 0;
        end
        if (src_ready) src_pulses++;
        if (c_valid && c_ready) got_c.push_back(c_data);
        if (done) done_cnt++;
        prev_stall     = cmd_valid && !cmd_ready;
        prev_payload   = cmd(cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1);
        prev_cmd_valid = cmd_valid;
        prev_c_stall   = c_valid && !c_ready;
        prev_c_data    = c_data;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 74'({cmd_valid, rsp_ready, src_ready, c_valid, busy, done}), 74'(0));
    check({tag, "_poll_cnt"}, 74'(poll_cnt), 74'(0));
    check({tag, "_payload"},
          cmd(cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1), 74'(0));
  endtask

  // One job: build the expected command/result stream from the job description, run it, compare.
  task automatic run_job(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n,
                         input logic [31:0] off, input int a, input int b, input int rows,
                         input int bp, input bit stall_a, input bit c_freeze, input bit rnd,
                         input bit spurious, input bit abort_stb);
    logic [73:0] exp_q[$];
    logic [31:0] exp_c[$];
    logic [31:0] w;
    int t0;
    @(posedge clk); #2;
    cfg_stall_a = stall_a; cfg_c_freeze = c_freeze; cfg_rnd = rnd;
    log_q.delete(); got_c.delete();
    src_pulses = 0; done_cnt = 0; busy_left = bp; outc_n = 0;
    valid_fire_cyc = -1; first_poll_cyc = -1; stb_seen = 0; c_frozen_done = 0;
    exp_q.push_back(cmd(F_RST, 32'h0, 32'h0));
    exp_q.push_back(cmd(F_KMN, {8'd0, k, m, n}, 32'h0));
    exp_q.push_back(cmd(F_OFS, off, 32'h0));
    for (int i = 0; i < a; i++) begin
      w = $urandom; src_q.push_back(w); exp_q.push_back(cmd(F_STA, w, 32'h0));
    end
    for (int i = 0; i < b; i++) begin
      w = $urandom; src_q.push_back(w); exp_q.push_back(cmd(F_STB, 32'h0, w));
    end
    exp_q.push_back(cmd(F_VALID, 32'h0, 32'h0));
    for (int i = 0; i <= bp; i++) exp_q.push_back(cmd(F_POLL, 32'h0, 32'h0));
    for (int r = 0; r < rows; r++)
      for (int l = 0; l < 4; l++) begin
        exp_q.push_back(cmd(F_OUTC, 32'(l), 32'h0));
        exp_c.push_back(c_word(r * 4 + l));
      end

    job_k = k; job_m = m; job_n = n; job_offset = off;
    a_count = 12'(a); b_count = 12'(b); c_rows = 12'(rows);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    job_k = $urandom; job_m = $urandom; job_n = $urandom; job_offset = $urandom;
    a_count = 12'($urandom); b_count = 12'($urandom); c_rows = 12'($urandom);
    check("busy_after_start", 74'(busy), 74'(1));

    if (spurious) begin
      repeat (6) @(posedge clk);
      #2;
      check("busy_before_spurious_start", 74'(busy), 74'(1));
      job_k = ~k; a_count = 12'd7; c_rows = 12'd9; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end

    if (abort_stb) begin
      t0 = cyc;
      while (!stb_seen && (cyc - t0) < 5000) @(posedge clk);
      #2;
      check("reached_stb_before_reset", 74'(stb_seen), 74'(1));
      reset = 1'b1;
      @(posedge clk); #2;
      check_reset_outputs("reset_in_stb");
      reset = 1'b0;
      return;
    end

    t0 = cyc;
    while (done_cnt == 0 && (cyc - t0) < 40000) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    check("done_pulses", 74'(done_cnt), 74'(1));
    check("busy_after_done", 74'({busy, done}), 74'(0));
    check("poll_cnt", 74'(poll_cnt), 74'(bp));
    check("src_ready_pulses", 74'(src_pulses), 74'(a + b));
    check("cmd_count", 74'(log_q.size()), 74'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("cmd[%0d]", i), (i < log_q.size()) ? log_q[i] : 74'bx, exp_q[i]);
    check("c_count", 74'(got_c.size()), 74'(exp_c.size()));
    for (int i = 0; i < exp_c.size(); i++)
      check($sformatf("c_data[%0d]", i), (i < got_c.size()) ? 74'(got_c[i]) : 74'bx, 74'(exp_c[i]));
    check("settle_gap", 74'(first_poll_cyc - valid_fire_cyc), 74'(SETTLE + 1));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("power_on_reset");
    reset = 1'b0;
    // Nominal 4x4x4 job, three busy polls, with a start pulse mid-job that must be ignored.
    run_job(8'd4, 8'd4, 8'd4, 32'h1234_5678, 4, 4, 1, 3, 0, 0, 0, 1, 0);
    // STORE_A held off for 5 cycles per word by the CFU.
    run_job(8'd3, 8'd5, 8'd7, $urandom, 3, 2, 2, 1, 1, 0, 0, 0, 0);
    // Result sink frozen for 20 cycles during readback.
    run_job(8'd2, 8'd2, 8'd9, $urandom, 2, 2, 3, 0, 0, 1, 0, 0, 0);
    // No A operands and no result rows.
    run_job(8'd1, 8'd1, 8'd1, $urandom, 0, 3, 0, 2, 0, 0, 0, 0, 0);
    // Reset in the middle of the B stream, then recovery.
    run_job(8'd6, 8'd6, 8'd6, $urandom, 2, 6, 1, 0, 0, 0, 1, 0, 1);
    for (int j = 0; j < 4; j++)
      run_job(8'($urandom), 8'($urandom), 8'($urandom), $urandom,
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
    // Largest A count the 12-bit counters allow.
    run_job(8'd255, 8'd1, 8'd16, $urandom, 4095, 1, 1, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
